// File: rtl/sobel_window_stream.sv
// sobel_window_stream: raster pixel stream to 3x3 Sobel windows via two BRAM line buffers.
// Define SOBEL_BORDER_REPLICATE_EN to clamp out-of-frame neighbours instead of zero-filling them.
module sobel_window_stream #(
    parameter int DW     = 8,
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 96
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [9*DW-1:0] out_win,
    output logic            out_border,
    output logic            out_eof
);
    localparam int PW = $clog2(WIDTH*HEIGHT+WIDTH+2);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
`ifdef SOBEL_BORDER_REPLICATE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif
    typedef enum logic {RUN, FLUSH} state_t;
    state_t r_state, w_state_n;
    logic [PW-1:0]   r_p;
    logic [CW-1:0]   r_col, r_cc, w_col_n;
    logic [RW-1:0]   r_cr;
    logic [DW-1:0]   r_lb0 [WIDTH];
    logic [DW-1:0]   r_lb1 [WIDTH];
    logic [DW-1:0]   r_rd0, r_rd1;
    logic [DW-1:0]   r_sr [3][2];
    logic [DW-1:0]   w_raw [3][3];
    logic [DW-1:0]   w_cf [3][3];
    logic [DW-1:0]   w_rf [3][3];
    logic [DW-1:0]   w_x;
    logic [9*DW-1:0] w_win;
    logic            w_go, w_adv, w_emit, w_last, w_lft, w_rgt, w_top, w_bot;

    assign w_go     = !out_valid | out_ready;
    assign in_ready = (r_state == RUN) & w_go;
    assign w_adv    = (in_valid & in_ready) | ((r_state == FLUSH) & w_go);
    assign w_x      = (r_state == FLUSH) ? '0 : in_data;
    assign w_emit   = w_adv & (r_p >= PW'(WIDTH+1));
    assign w_lft    = r_cc == '0;
    assign w_rgt    = r_cc == CW'(WIDTH-1);
    assign w_top    = r_cr == '0;
    assign w_bot    = r_cr == RW'(HEIGHT-1);
    assign w_last   = w_emit & w_rgt & w_bot;
    // Read address runs one column ahead so the synchronous BRAM read is ready at the next advance
    assign w_col_n  = rst ? '0 : !w_adv ? r_col :
                      (w_last || r_col == CW'(WIDTH-1)) ? '0 : r_col + 1'b1;

    always_comb begin
        w_win = '0;
        for (int i = 0; i < 3; i++) begin
            w_raw[i][0] = r_sr[i][0];
            w_raw[i][1] = r_sr[i][1];
            w_raw[i][2] = (i == 0) ? r_rd1 : (i == 1) ? r_rd0 : w_x;
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w_cf[i][j] = ((j == 0 && w_lft) || (j == 2 && w_rgt)) ? (REPL ? w_raw[i][1] : '0) : w_raw[i][j];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                w_rf[i][j] = ((i == 0 && w_top) || (i == 2 && w_bot)) ? (REPL ? w_cf[1][j] : '0) : w_cf[i][j];
                w_win[(i*3+j)*DW +: DW] = w_rf[i][j];
            end
    end

    always_comb
        w_state_n = (r_state == RUN && in_valid && in_ready && r_p == PW'(WIDTH*HEIGHT-1)) ? FLUSH :
                    (r_state == FLUSH && w_last) ? RUN : r_state;

    always_ff @(posedge clk)
        if (rst) r_state <= RUN;
        else     r_state <= w_state_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p        <= '0;
            r_col      <= '0;
            r_cc       <= '0;
            r_cr       <= '0;
            out_valid  <= 1'b0;
            out_win    <= '0;
            out_border <= 1'b0;
            out_eof    <= 1'b0;
        end else begin
            r_col <= w_col_n;
            if (w_adv) r_p <= w_last ? '0 : r_p + 1'b1;
            if (w_emit) begin
                r_cc <= w_rgt ? '0 : r_cc + 1'b1;
                if (w_rgt) r_cr <= w_bot ? '0 : r_cr + 1'b1;
                out_win    <= w_win;
                out_border <= w_lft | w_rgt | w_top | w_bot;
                out_eof    <= w_last;
            end
            if (w_go) out_valid <= w_emit;
        end
    end

    // Line buffers and column shift register carry no reset; stale content is masked at the borders
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_lb0[r_col] <= w_x;
            r_lb1[r_col] <= r_rd0;
            for (int i = 0; i < 3; i++) begin
                r_sr[i][0] <= r_sr[i][1];
                r_sr[i][1] <= w_raw[i][2];
            end
        end
        r_rd0 <= r_lb0[w_col_n];
        r_rd1 <= r_lb1[w_col_n];
    end
endmodule

// File: tb/tb_sobel_window_stream.sv
// tb_sobel_window_stream: directed checks of the 3x3 window stream on a 4x3 frame.
module tb_sobel_window_stream;
    localparam int DW = 8, W = 4, H = 3;
    logic            clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic            in_ready, out_valid, out_border, out_eof;
    logic [DW-1:0]   in_data = '0;
    logic [9*DW-1:0] out_win;
    int n_vec = 0, n_err = 0;
    int cyc = 0, acc_cyc = -1, ov_cyc = -1;
    logic [9*DW-1:0] q_win [$];
    logic            q_bor [$];
    logic            q_eof [$];
    int              pend [$];

    always #5 clk = ~clk;

    sobel_window_stream #(.DW(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
        .out_border(out_border), .out_eof(out_eof));

    always @(negedge clk) begin
        cyc++;
        if (!rst && out_valid && out_ready) begin
            q_win.push_back(out_win);
            q_bor.push_back(out_border);
            q_eof.push_back(out_eof);
        end
        if (!rst && in_valid && in_ready && acc_cyc < 0) acc_cyc = cyc;
        if (!rst && out_valid && ov_cyc < 0) ov_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        pk = {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    function automatic int px(input int base, input int r, input int c);
`ifdef SOBEL_BORDER_REPLICATE_EN
        r = (r < 0) ? 0 : (r > H-1) ? H-1 : r;
        c = (c < 0) ? 0 : (c > W-1) ? W-1 : c;
`else
        if (r < 0 || r > H-1 || c < 0 || c > W-1) return 0;
`endif
        return base + r*W + c + 1;
    endfunction

    function automatic logic [9*DW-1:0] exp_win(input int base, input int r, input int c);
        exp_win = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                exp_win[(i*3+j)*DW +: DW] = DW'(px(base, r+i-1, c+j-1));
    endfunction

    task automatic clear_q();
        q_win.delete(); q_bor.delete(); q_eof.delete();
    endtask

    task automatic load(input int base);
        for (int k = 1; k <= W*H; k++) pend.push_back(base + k);
    endtask

    task automatic run(input string tag, input int target, input bit gaps, input int stall_at, input int bound);
        int sc = 0;
        bit done = 1'b0;
        logic [9*DW-1:0] held = '0;
        for (int k = 0; k < bound; k++) begin
            if (pend.size() == 0 && q_win.size() >= target) break;
            in_valid = pend.size() > 0 && (!gaps || $urandom_range(0, 3) != 0);
            in_data  = pend.size() > 0 ? DW'(pend[0]) : '0;
            if (stall_at >= 0 && !done && q_win.size() == stall_at && out_valid) begin
                sc = 5; held = out_win; done = 1'b1;
            end
            out_ready = (sc > 0) ? 1'b0 : (!gaps || $urandom_range(0, 2) != 0);
            @(negedge clk);
            if (sc > 0) begin
                chk({tag, " stall valid"}, out_valid, 1);
                chk({tag, " stall win"}, out_win, held);
                chk({tag, " stall in_ready"}, in_ready, 0);
                sc--;
            end
            if (in_valid && in_ready) void'(pend.pop_front());
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk({tag, " completion"}, (pend.size() == 0 && q_win.size() >= target) ? 1 : 0, 1);
    endtask

    task automatic cmp_stream(input string tag, input int nf, input int b0, input int b1, input int b2);
        int n, base;
        chk({tag, " count"}, q_win.size(), nf*W*H);
        n = (q_win.size() < nf*W*H) ? q_win.size() : nf*W*H;
        for (int k = 0; k < n; k++) begin
            int f = k / (W*H), r = (k % (W*H)) / W, c = k % W;
            base = (f == 0) ? b0 : (f == 1) ? b1 : b2;
            chk($sformatf("%s win%0d", tag, k), q_win[k], exp_win(base, r, c));
            chk($sformatf("%s bor%0d", tag, k), q_bor[k], (r == 0 || r == H-1 || c == 0 || c == W-1) ? 1 : 0);
            chk($sformatf("%s eof%0d", tag, k), q_eof[k], (r == H-1 && c == W-1) ? 1 : 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst valid", out_valid, 0);
        chk("rst win", out_win, 0);
        chk("rst border", out_border, 0);
        chk("rst eof", out_eof, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst in_ready", in_ready, 1);
        @(posedge clk); #1;

        clear_q(); acc_cyc = -1; ov_cyc = -1;
        load(0);
        run("t1", 12, 1'b0, -1, 200);
        chk("t1 latency", ov_cyc - acc_cyc, W+2);
`ifdef SOBEL_BORDER_REPLICATE_EN
        chk("t2 first", q_win[0], pk(1, 1, 2, 1, 1, 2, 5, 5, 6));
        chk("t2 last", q_win[11], pk(7, 8, 8, 11, 12, 12, 11, 12, 12));
`else
        chk("t1 first", q_win[0], pk(0, 0, 0, 0, 1, 2, 0, 5, 6));
        chk("t1 last", q_win[11], pk(7, 8, 0, 11, 12, 0, 0, 0, 0));
`endif
        chk("t1 centre6", q_win[5], pk(1, 2, 3, 5, 6, 7, 9, 10, 11));
        chk("t1 centre6 border", q_bor[5], 0);
        chk("t1 first border", q_bor[0], 1);
        chk("t1 last eof", q_eof[11], 1);
        cmp_stream("t1", 1, 0, 0, 0);

        clear_q();
        load(0);
        run("t3", 12, 1'b0, 2, 300);
        cmp_stream("t3", 1, 0, 0, 0);

        clear_q();
        for (int k = 1; k <= 7; k++) pend.push_back(k);
        run("t4 part", 0, 1'b0, -1, 50);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t4 rst valid", out_valid, 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        clear_q();
        load(0);
        run("t4", 12, 1'b0, -1, 200);
        cmp_stream("t4", 1, 0, 0, 0);

        clear_q();
        load(0); load(100);
        run("t5", 24, 1'b0, -1, 400);
`ifdef SOBEL_BORDER_REPLICATE_EN
        chk("t5 f2 first", q_win[12], exp_win(100, 0, 0));
`else
        chk("t5 f2 first", q_win[12], pk(0, 0, 0, 0, 101, 102, 0, 105, 106));
`endif
        cmp_stream("t5", 2, 0, 100, 0);

        clear_q();
        load(0); load(100); load(200);
        run("t6", 36, 1'b1, -1, 3000);
        cmp_stream("t6", 3, 0, 100, 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
